// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and reset-image helper for the decode-stage register file.
// No logic, no latency; write-backs are never backpressured.
package regfile_scoreboard_pkg;

    localparam int          DATA_W_DEF   = 32;
    localparam int          ADDR_W_DEF   = 5;
    localparam int          LINK_IDX_DEF = 31;
    localparam int          SP_IDX_DEF   = 29;
    localparam logic [31:0] SP_INIT_DEF  = 32'h0000_7FFF;
    localparam logic [63:0] REG0_VAL     = 64'd0;

    // Reset image: every register holds its own index, except reg0 and the stack pointer.
    function automatic logic [63:0] reset_value(input int k, input int sp_idx, input logic [63:0] sp_init);
        if (k == 0) begin
            return REG0_VAL;
        end else if (k == sp_idx) begin
            return sp_init;
        end
        return 64'(k);
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter.sv
// Per-address winning write: link channel beats wr ports, higher wr port beats lower.
// Purely combinational, 0 cycles; never backpressures.
module regfile_wr_arbiter
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NWR      = 2,
    parameter int LINK_IDX = LINK_IDX_DEF
) (
    input  logic [NWR-1:0]                      wr_en_i,
    input  logic [NWR*ADDR_W-1:0]               wr_addr_i,
    input  logic [NWR*DATA_W-1:0]               wr_data_i,
    input  logic                                link_en_i,
    input  logic                                link_take_i,
    input  logic [DATA_W-1:0]                   link_data_i,
    output logic [(1<<ADDR_W)-1:0]              hit_o,
    output logic [(1<<ADDR_W)-1:0][DATA_W-1:0]  data_o
);

    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_IDX);

    always_comb begin
        hit_o  = '0;
        data_o = '0;
        // Ascending scan lets the highest-numbered port overwrite earlier winners.
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j] && (wr_addr_i[j*ADDR_W +: ADDR_W] != '0)) begin
                hit_o[wr_addr_i[j*ADDR_W +: ADDR_W]]  = 1'b1;
                data_o[wr_addr_i[j*ADDR_W +: ADDR_W]] = wr_data_i[j*DATA_W +: DATA_W];
            end
        end
        if (link_en_i && link_take_i && (LINK_A != '0)) begin
            hit_o[LINK_A]  = 1'b1;
            data_o[LINK_A] = link_data_i;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with pending-write scoreboard, optional write->read bypass and link channel.
// Reads/stall combinational; writes commit at posedge; writes never stalled, issue_stall_o gates decode only.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                NRD      = 2,
    parameter int                NWR      = 2,
    parameter int                LINK_IDX = LINK_IDX_DEF,
    parameter int                SP_IDX   = SP_IDX_DEF,
    parameter logic [DATA_W-1:0] SP_INIT  = DATA_W'(SP_INIT_DEF),
    parameter int                BYPASS   = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NRD-1:0]          rd_en_i,
    input  logic [NRD*ADDR_W-1:0]   rd_addr_i,
    output logic [NRD*DATA_W-1:0]   rd_data_o,
    output logic [NRD-1:0]          rd_busy_o,
    output logic                    issue_stall_o,
    input  logic                    sb_set_en_i,
    input  logic [ADDR_W-1:0]       sb_set_addr_i,
    input  logic [NWR-1:0]          wr_en_i,
    input  logic [NWR*ADDR_W-1:0]   wr_addr_i,
    input  logic [NWR*DATA_W-1:0]   wr_data_i,
    input  logic                    link_en_i,
    input  logic                    link_take_i,
    input  logic [DATA_W-1:0]       link_data_i
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]              regs_q [DEPTH];
    logic [DATA_W-1:0]              regs_d [DEPTH];
    logic [DEPTH-1:0]               busy_q;
    logic [DEPTH-1:0]               busy_d;
    logic [DEPTH-1:0]               wr_hit;
    logic [DEPTH-1:0][DATA_W-1:0]   wr_dat;
    logic                           dest_busy;
    logic                           set_ok;

    regfile_wr_arbiter #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NWR      (NWR),
        .LINK_IDX (LINK_IDX)
    ) u_arb (
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .link_en_i   (link_en_i),
        .link_take_i (link_take_i),
        .link_data_i (link_data_i),
        .hit_o       (wr_hit),
        .data_o      (wr_dat)
    );

    // A destination retiring this cycle is free for a new issue (younger writer takes over).
    assign dest_busy = busy_q[sb_set_addr_i] & ~wr_hit[sb_set_addr_i];
    assign set_ok    = sb_set_en_i && (sb_set_addr_i != '0) && !dest_busy;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q & ~wr_hit;
        for (int k = 0; k < DEPTH; k++) begin
            if (wr_hit[k]) begin
                regs_d[k] = wr_dat[k];
            end
        end
        if (set_ok) begin
            busy_d[sb_set_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= DATA_W'(reset_value(k, SP_IDX, 64'(SP_INIT)));
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int i = 0; i < NRD; i++) begin
            if (rd_addr_i[i*ADDR_W +: ADDR_W] == '0) begin
                rd_data_o[i*DATA_W +: DATA_W] = DATA_W'(REG0_VAL);
            end else if ((BYPASS != 0) && wr_hit[rd_addr_i[i*ADDR_W +: ADDR_W]]) begin
                rd_data_o[i*DATA_W +: DATA_W] = wr_dat[rd_addr_i[i*ADDR_W +: ADDR_W]];
            end else begin
                rd_data_o[i*DATA_W +: DATA_W] = regs_q[rd_addr_i[i*ADDR_W +: ADDR_W]];
                rd_busy_o[i]                  = busy_q[rd_addr_i[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    assign issue_stall_o = (|(rd_en_i & rd_busy_o)) | (sb_set_en_i & dest_busy);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized + directed bench for regfile_scoreboard; bypass and non-bypass instances against one model.
module tb_regfile_scoreboard;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [1:0]   rd_en = '0;
    logic [9:0]   rd_addr = '0;
    logic         sb_set_en = 1'b0;
    logic [4:0]   sb_set_addr = '0;
    logic [1:0]   wr_en = '0;
    logic [9:0]   wr_addr = '0;
    logic [63:0]  wr_data = '0;
    logic         link_en = 1'b0;
    logic         link_take = 1'b0;
    logic [31:0]  link_data = '0;

    logic [63:0]  b_rd_data, n_rd_data;
    logic [1:0]   b_rd_busy, n_rd_busy;
    logic         b_stall, n_stall;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_reg [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    regfile_scoreboard #(.BYPASS(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(b_rd_data), .rd_busy_o(b_rd_busy), .issue_stall_o(b_stall),
        .sb_set_en_i(sb_set_en), .sb_set_addr_i(sb_set_addr), .wr_en_i(wr_en),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .link_en_i(link_en),
        .link_take_i(link_take), .link_data_i(link_data)
    );

    regfile_scoreboard #(.BYPASS(0)) u_nb (
        .clk_i(clk), .rst_ni(rst_n), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(n_rd_data), .rd_busy_o(n_rd_busy), .issue_stall_o(n_stall),
        .sb_set_en_i(sb_set_en), .sb_set_addr_i(sb_set_addr), .wr_en_i(wr_en),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .link_en_i(link_en),
        .link_take_i(link_take), .link_data_i(link_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Value written to address a this cycle, if any: link over ports, later port over earlier.
    function automatic void winner(input logic [4:0] a, output bit v, output logic [31:0] d);
        v = 1'b0;
        d = '0;
        if (a == 5'd0) return;
        for (int j = 0; j < 2; j++) begin
            if (wr_en[j] && wr_addr[j*5 +: 5] == a) begin
                v = 1'b1;
                d = wr_data[j*32 +: 32];
            end
        end
        if (link_en && link_take && a == 5'd31) begin
            v = 1'b1;
            d = link_data;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) begin
                m_reg[k]  = (k == 29) ? 32'h7FFF : 32'(k);
                m_busy[k] = 1'b0;
            end
        end else begin
            bit          v, sv, set_go;
            logic [31:0] d, sd;
            winner(sb_set_addr, sv, sd);
            set_go = sb_set_en && sb_set_addr != 5'd0 && !(m_busy[sb_set_addr] && !sv);
            for (int k = 1; k < 32; k++) begin
                winner(5'(k), v, d);
                if (v) begin
                    m_reg[k]  = d;
                    m_busy[k] = 1'b0;
                end
            end
            if (set_go) m_busy[sb_set_addr] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit          v, sv, b_st, n_st, set_blk;
            logic [31:0] d, sd, eb_d, en_d;
            bit          eb_b, en_b;
            winner(sb_set_addr, sv, sd);
            set_blk = sb_set_en && m_busy[sb_set_addr] && !sv;
            b_st = set_blk;
            n_st = set_blk;
            for (int i = 0; i < 2; i++) begin
                logic [4:0] a;
                a = rd_addr[i*5 +: 5];
                winner(a, v, d);
                en_d = (a == 5'd0) ? 32'd0 : m_reg[a];
                en_b = (a == 5'd0) ? 1'b0 : m_busy[a];
                eb_d = v ? d : en_d;
                eb_b = v ? 1'b0 : en_b;
                b_st = b_st | (rd_en[i] & eb_b);
                n_st = n_st | (rd_en[i] & en_b);
                chk($sformatf("byp_rd_data%0d", i), 64'(b_rd_data[i*32 +: 32]), 64'(eb_d));
                chk($sformatf("byp_rd_busy%0d", i), 64'(b_rd_busy[i]), 64'(eb_b));
                chk($sformatf("nb_rd_data%0d", i), 64'(n_rd_data[i*32 +: 32]), 64'(en_d));
                chk($sformatf("nb_rd_busy%0d", i), 64'(n_rd_busy[i]), 64'(en_b));
            end
            chk("byp_stall", 64'(b_stall), 64'(b_st));
            chk("nb_stall", 64'(n_stall), 64'(n_st));
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = '0; rd_addr = '0; sb_set_en = 1'b0; sb_set_addr = '0;
        wr_en = '0; wr_addr = '0; wr_data = '0;
        link_en = 1'b0; link_take = 1'b0; link_data = '0;
    endtask

    function automatic logic [4:0] rnd_addr();
        return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    initial begin
        #2 rst_n = 1'b0;
        #10;
        next();
        rst_n = 1'b1;
        chk_en = 1'b1;

        rd_en = 2'b11; rd_addr = {5'd29, 5'd5}; #2;
        chk("rst_reg5", 64'(b_rd_data[31:0]), 64'd5);
        chk("rst_reg29", 64'(b_rd_data[63:32]), 64'h7FFF);
        chk("rst_busy", 64'(b_rd_busy), 64'd0);
        chk("rst_stall", 64'(b_stall), 64'd0);
        rd_addr = {5'd29, 5'd0}; #1;
        chk("rst_reg0", 64'(b_rd_data[31:0]), 64'd0);

        next(); idle();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd8}; wr_data = {32'd0, 32'hDEAD}; rd_addr = {5'd0, 5'd8}; #2;
        chk("bypass_new", 64'(b_rd_data[31:0]), 64'hDEAD);
        chk("nobypass_old", 64'(n_rd_data[31:0]), 64'd8);

        next(); idle();
        wr_en = 2'b11; wr_addr = {5'd4, 5'd4}; wr_data = {32'h22, 32'h11};
        link_en = 1'b1; link_take = 1'b1; link_data = 32'h400;
        next(); idle();
        rd_addr = {5'd31, 5'd4}; #2;
        chk("conflict_reg4", 64'(n_rd_data[31:0]), 64'h22);
        chk("conflict_reg31", 64'(n_rd_data[63:32]), 64'h400);

        next(); idle();
        sb_set_en = 1'b1; sb_set_addr = 5'd9;
        next(); idle();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd9}; #2;
        chk("sb_busy9", 64'(b_rd_busy[0]), 64'd1);
        chk("sb_stall9", 64'(b_stall), 64'd1);
        next(); idle();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'd0, 32'h99};
        sb_set_en = 1'b1; sb_set_addr = 5'd9; #2;
        chk("sb_setclr_stall", 64'(b_stall), 64'd0);
        next(); idle();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd9}; #2;
        chk("sb_still_busy9", 64'(n_rd_busy[0]), 64'd1);
        chk("sb_reg9", 64'(n_rd_data[31:0]), 64'h99);

        next(); idle();
        link_en = 1'b1; link_take = 1'b0; link_data = 32'h123;
        next(); idle();
        rd_addr = {5'd0, 5'd31}; #2;
        chk("link_not_taken", 64'(n_rd_data[31:0]), 64'h400);
        next(); idle();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'd0, 32'd5};
        sb_set_en = 1'b1; sb_set_addr = 5'd0;
        next(); idle();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd0}; #2;
        chk("reg0_data", 64'(n_rd_data[31:0]), 64'd0);
        chk("reg0_busy", 64'(n_rd_busy[0]), 64'd0);
        chk("reg0_stall", 64'(n_stall), 64'd0);

        next(); idle();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'hFF};
        next(); idle(); sb_set_en = 1'b1; sb_set_addr = 5'd3;
        next(); idle(); sb_set_en = 1'b1; sb_set_addr = 5'd7;
        next(); idle();
        rd_en = 2'b11; rd_addr = {5'd7, 5'd3}; #2;
        chk("pre_rst_busy", 64'(b_rd_busy), 64'd3);
        chk("pre_rst_reg3", 64'(b_rd_data[31:0]), 64'hFF);
        rst_n = 1'b0; #1;
        chk("arst_reg3", 64'(b_rd_data[31:0]), 64'd3);
        chk("arst_reg7", 64'(b_rd_data[63:32]), 64'd7);
        chk("arst_busy", 64'(b_rd_busy), 64'd0);
        chk("arst_stall", 64'(b_stall), 64'd0);
        next();
        rst_n = 1'b1;

        repeat (800) begin
            next();
            rd_en       = 2'($urandom_range(0, 3));
            rd_addr     = {rnd_addr(), rnd_addr()};
            sb_set_en   = ($urandom_range(0, 9) < 3);
            sb_set_addr = rnd_addr();
            wr_en       = 2'($urandom_range(0, 3));
            wr_addr     = {rnd_addr(), rnd_addr()};
            wr_data     = {$urandom(), $urandom()};
            link_en     = ($urandom_range(0, 4) == 0);
            link_take   = ($urandom_range(0, 1) == 0);
            link_data   = $urandom();
            rd_addr[4:0] = (($urandom_range(0, 3) == 0) && link_en) ? 5'd31 : rd_addr[4:0];
        end
        next(); idle();
        @(posedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
